// File: rtl/ps2_device_port_if.sv
// ============================================================================
// Module   : ps2_device_port_if
// Brief    : Core-side byte interface of the device-end PS/2 port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_device_port_if;
    logic [7:0] din;
    logic       load;
    logic       busy;
    logic       tx_done;
    logic       tx_abort;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    modport master (
        output din, load,
        input  busy, tx_done, tx_abort, rx_data, rx_valid, rx_error
    );

    modport slave (
        input  din, load,
        output busy, tx_done, tx_abort, rx_data, rx_valid, rx_error
    );
endinterface

`default_nettype wire

// File: rtl/ps2_device_port.sv
// ============================================================================
// Module   : ps2_device_port
// Brief    : Device-end PS/2 port: drives the PS/2 clock, sends bytes to the
//            host and receives host commands with the ACK handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_device_port #(
    parameter int HALF_PERIOD = 1120,
    parameter int IDLE_GAP    = 1400,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire              clkps2,
    inout  wire              dataps2,
    ps2_device_port_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_GAP   = 3'd1,
        ST_TX_BITS  = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_RX_FLUSH = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_half_mid  = CNT_W'(HALF_PERIOD / 2);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] c_sync      = CNT_W'(2);
    // ACK data is let go a few cycles early so the synchronized line is high
    // again by the time IDLE starts looking for a request-to-send.
    localparam logic [CNT_W-1:0] c_ack_rel   = CNT_W'(HALF_PERIOD - 4);

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [3:0]       r_bit, w_bit_n;
    logic             r_low_half, w_low_n;
    logic [10:0]      r_shift, w_shift_n;
    logic             r_clk_low, w_clk_low_n;
    logic             r_dat_low, w_dat_low_n;
    logic [7:0]       r_rx_data, w_rx_data_n;
    logic             r_tx_done, w_tx_done_n;
    logic             r_tx_abort, w_tx_abort_n;
    logic             r_rx_valid, w_rx_valid_n;
    logic             r_rx_error, w_rx_error_n;
    logic [1:0]       r_clk_sync, r_dat_sync;
    logic             w_clk_s, w_dat_s, w_half_end;

    assign clkps2  = r_clk_low ? 1'b0 : 1'bz;
    assign dataps2 = r_dat_low ? 1'b0 : 1'bz;

    assign w_clk_s    = r_clk_sync[1];
    assign w_dat_s    = r_dat_sync[1];
    assign w_half_end = (r_cnt == c_half_last);

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.tx_done  = r_tx_done;
    assign bus.tx_abort = r_tx_abort;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_error = r_rx_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], clkps2};
            r_dat_sync <= {r_dat_sync[0], dataps2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_low_half <= 1'b0;
            r_shift    <= '0;
            r_clk_low  <= 1'b0;
            r_dat_low  <= 1'b0;
            r_rx_data  <= '0;
            r_tx_done  <= 1'b0;
            r_tx_abort <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_low_half <= w_low_n;
            r_shift    <= w_shift_n;
            r_clk_low  <= w_clk_low_n;
            r_dat_low  <= w_dat_low_n;
            r_rx_data  <= w_rx_data_n;
            r_tx_done  <= w_tx_done_n;
            r_tx_abort <= w_tx_abort_n;
            r_rx_valid <= w_rx_valid_n;
            r_rx_error <= w_rx_error_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_bit_n      = r_bit;
        w_low_n      = r_low_half;
        w_shift_n    = r_shift;
        w_clk_low_n  = r_clk_low;
        w_dat_low_n  = r_dat_low;
        w_rx_data_n  = r_rx_data;
        w_tx_done_n  = 1'b0;
        w_tx_abort_n = 1'b0;
        w_rx_valid_n = 1'b0;
        w_rx_error_n = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clk_low_n = 1'b0;
                w_dat_low_n = 1'b0;
                if (w_clk_s && !w_dat_s) begin
                    w_state_n   = ST_RX;
                    w_cnt_n     = '0;
                    w_bit_n     = '0;
                    w_low_n     = 1'b1;
                    w_clk_low_n = 1'b1;
                end else if (bus.load) begin
                    w_shift_n = {1'b1, ~^bus.din, bus.din, 1'b0};
                    w_state_n = ST_TX_GAP;
                    w_cnt_n   = '0;
                end
            end

            ST_TX_GAP: begin
                if (!w_dat_s) begin
                    w_state_n   = ST_RX;
                    w_cnt_n     = '0;
                    w_bit_n     = '0;
                    w_low_n     = 1'b1;
                    w_clk_low_n = 1'b1;
                end else if (!w_clk_s) begin
                    w_cnt_n = '0;
                end else if (r_cnt == c_gap_last) begin
                    w_state_n   = ST_TX_BITS;
                    w_cnt_n     = '0;
                    w_bit_n     = '0;
                    w_low_n     = 1'b0;
                    w_dat_low_n = ~r_shift[0];
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            // Each transmitted bit: released-high half, then driven-low half.
            ST_TX_BITS: begin
                if (!r_low_half) begin
                    if (r_cnt >= c_sync && !w_clk_s && r_bit <= 4'd9) begin
                        w_state_n    = ST_IDLE;
                        w_cnt_n      = '0;
                        w_clk_low_n  = 1'b0;
                        w_dat_low_n  = 1'b0;
                        w_tx_abort_n = 1'b1;
                    end else if (w_half_end) begin
                        w_cnt_n     = '0;
                        w_low_n     = 1'b1;
                        w_clk_low_n = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end else if (w_half_end) begin
                    if (r_bit == 4'd10) begin
                        w_state_n   = ST_IDLE;
                        w_cnt_n     = '0;
                        w_clk_low_n = 1'b0;
                        w_dat_low_n = 1'b0;
                        w_tx_done_n = 1'b1;
                    end else begin
                        w_cnt_n     = '0;
                        w_low_n     = 1'b0;
                        w_clk_low_n = 1'b0;
                        w_bit_n     = r_bit + 1'b1;
                        w_shift_n   = {1'b1, r_shift[10:1]};
                        w_dat_low_n = ~r_shift[1];
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            // Receive clocks run low half first so the host can set each bit
            // while the clock is low; samples shift in at bit 10 downwards.
            ST_RX, ST_RX_FLUSH: begin
                if (r_low_half) begin
                    if (w_half_end) begin
                        w_cnt_n     = '0;
                        w_low_n     = 1'b0;
                        w_clk_low_n = 1'b0;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end else begin
                    if (r_cnt == c_half_mid) begin
                        w_shift_n = {w_dat_s, r_shift[10:1]};
                    end
                    if (w_half_end) begin
                        w_cnt_n     = '0;
                        w_low_n     = 1'b1;
                        w_clk_low_n = 1'b1;
                        w_bit_n     = r_bit + 1'b1;
                        if (r_state == ST_RX && r_bit == 4'd9) begin
                            w_bit_n     = '0;
                            w_state_n   = r_shift[10] ? ST_RX_ACK : ST_RX_FLUSH;
                            w_dat_low_n = r_shift[10];
                        end else if (r_state == ST_RX_FLUSH &&
                                     (r_shift[10] || r_bit == 4'd7)) begin
                            w_state_n    = ST_IDLE;
                            w_low_n      = 1'b0;
                            w_clk_low_n  = 1'b0;
                            w_rx_error_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end

            ST_RX_ACK: begin
                if (r_low_half) begin
                    if (w_half_end) begin
                        w_cnt_n     = '0;
                        w_low_n     = 1'b0;
                        w_clk_low_n = 1'b0;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end else begin
                    if (r_cnt == c_ack_rel) begin
                        w_dat_low_n = 1'b0;
                    end
                    if (w_half_end) begin
                        w_state_n   = ST_IDLE;
                        w_cnt_n     = '0;
                        w_clk_low_n = 1'b0;
                        w_dat_low_n = 1'b0;
                        if (^r_shift[9:1]) begin
                            w_rx_data_n  = r_shift[8:1];
                            w_rx_valid_n = 1'b1;
                        end else begin
                            w_rx_error_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_n   = ST_IDLE;
                w_clk_low_n = 1'b0;
                w_dat_low_n = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_device_port.sv
// ============================================================================
// Module   : tb_ps2_device_port
// Brief    : Directed bench for ps2_device_port with a behavioural PS/2 host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_device_port;
    localparam int HP  = 20;
    localparam int GAP = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic h_clk_low = 1'b0;
    logic h_dat_low = 1'b0;
    wire  clkps2;
    wire  dataps2;

    assign clkps2  = h_clk_low ? 1'b0 : 1'bz;
    assign dataps2 = h_dat_low ? 1'b0 : 1'bz;
    pullup (clkps2);
    pullup (dataps2);

    ps2_device_port_if bus ();

    ps2_device_port #(.HALF_PERIOD(HP), .IDLE_GAP(GAP), .CNT_W(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clkps2  (clkps2),
        .dataps2 (dataps2),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0, fall_n = 0, rec_n = 0;
    int   n_done = 0, n_abort = 0, n_valid = 0, n_error = 0;
    logic rec_en = 1'b0;
    logic ps2_prev = 1'b1;
    logic rec_mem [0:255];
    int   rec_cyc [0:255];

    // Host-side observer: counts pulses and records data on PS/2 falling edges.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.tx_done  === 1'b1) n_done  = n_done + 1;
        if (bus.tx_abort === 1'b1) n_abort = n_abort + 1;
        if (bus.rx_valid === 1'b1) n_valid = n_valid + 1;
        if (bus.rx_error === 1'b1) n_error = n_error + 1;
        if (ps2_prev === 1'b1 && clkps2 === 1'b0) begin
            fall_n = fall_n + 1;
            if (rec_en && rec_n < 256) begin
                rec_mem[rec_n] = dataps2;
                rec_cyc[rec_n] = cyc;
                rec_n = rec_n + 1;
            end
        end
        ps2_prev = clkps2;
    end

    task automatic do_load(input logic [7:0] d);
        @(negedge clk);
        bus.din  = d;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic host_send(input logic [7:0] d, input logic p, output logic ok);
        int f0;
        ok = 1'b1;
        h_clk_low = 1'b1;
        repeat (70) @(negedge clk);
        h_dat_low = 1'b1;
        repeat (5) @(negedge clk);
        h_clk_low = 1'b0;
        f0 = fall_n;
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < 6 * HP && fall_n <= f0 + i; k++) @(negedge clk);
            if (fall_n <= f0 + i) begin
                ok = 1'b0;
                h_dat_low = 1'b0;
                return;
            end
            if (i < 8)       h_dat_low = ~d[i];
            else if (i == 8) h_dat_low = ~p;
            else             h_dat_low = 1'b0;
        end
    endtask

    task automatic test_reset;
        bus.din  = 8'h00;
        bus.load = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (clkps2 !== 1'b1 || dataps2 !== 1'b1) begin errors++; $display("FAIL reset_lines: got clk=%b data=%b expected 1 1", clkps2, dataps2); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
        checks++; if ({bus.tx_done, bus.tx_abort, bus.rx_valid, bus.rx_error} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000", {bus.tx_done, bus.tx_abort, bus.rx_valid, bus.rx_error}); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_transmit;
        int base, d0, l_cyc;
        logic [10:0] got;
        base = rec_n; d0 = n_done; rec_en = 1'b1;
        do_load(8'hFA);
        l_cyc = cyc;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tx_busy: got %b expected 1", bus.busy); end
        for (int k = 0; k < 2000 && n_done == d0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        rec_en = 1'b0;
        for (int i = 0; i < 11; i++) got[i] = rec_mem[base + i];
        checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL tx_done_count: got %0d expected %0d", n_done - d0, 1); end
        checks++; if (rec_n - base != 11) begin errors++; $display("FAIL tx_bit_count: got %0d expected 11", rec_n - base); end
        checks++; if (got !== 11'b11111110100) begin errors++; $display("FAIL tx_frame_FA: got %b expected %b", got, 11'b11111110100); end
        checks++; if (rec_cyc[base] - l_cyc < GAP) begin errors++; $display("FAIL tx_idle_gap: got %0d cycles expected >= %0d", rec_cyc[base] - l_cyc, GAP); end
        checks++; if (bus.busy !== 1'b0 || clkps2 !== 1'b1 || dataps2 !== 1'b1) begin
            errors++; $display("FAIL tx_end_state: got busy=%b clk=%b data=%b expected 0 1 1", bus.busy, clkps2, dataps2); end
    endtask

    task automatic test_back_to_back;
        int base, d0;
        logic [10:0] got;
        base = rec_n; d0 = n_done; rec_en = 1'b1;
        do_load(8'hAA);
        for (int k = 0; k < 2000 && rec_n - base < 3; k++) @(negedge clk);
        do_load(8'h12);
        for (int k = 0; k < 2000 && n_done == d0; k++) @(negedge clk);
        repeat (GAP + 6 * HP) @(negedge clk);
        rec_en = 1'b0;
        for (int i = 0; i < 11; i++) got[i] = rec_mem[base + i];
        checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", n_done - d0); end
        checks++; if (rec_n - base != 11) begin errors++; $display("FAIL b2b_bit_count: got %0d expected 11", rec_n - base); end
        checks++; if (got !== 11'b11101010100) begin errors++; $display("FAIL b2b_frame_AA: got %b expected %b", got, 11'b11101010100); end
    endtask

    task automatic test_inhibit;
        int base, d0, a0, k;
        base = rec_n; d0 = n_done; a0 = n_abort; rec_en = 1'b1;
        do_load(8'h55);
        for (k = 0; k < 2000 && rec_n - base < 5; k++) @(negedge clk);
        rec_en = 1'b0;
        checks++; if (rec_n - base != 5) begin errors++; $display("FAIL inh_reach_bit: got %0d falls expected 5", rec_n - base); end
        repeat (HP + 4) @(negedge clk);
        h_clk_low = 1'b1;
        for (k = 0; k < HP + 3 && n_abort == a0; k++) @(negedge clk);
        checks++; if (n_abort != a0 + 1) begin errors++; $display("FAIL inh_abort: got %0d pulses expected 1 within %0d cycles", n_abort - a0, HP + 3); end
        checks++; if (dataps2 !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL inh_release: got data=%b busy=%b expected 1 0", dataps2, bus.busy); end
        repeat (70 - k) @(negedge clk);
        h_clk_low = 1'b0;
        repeat (2 * GAP + 4 * HP) @(negedge clk);
        checks++; if (n_done != d0) begin errors++; $display("FAIL inh_no_done: got %0d expected 0", n_done - d0); end
        checks++; if (n_abort != a0 + 1) begin errors++; $display("FAIL inh_abort_once: got %0d expected 1", n_abort - a0); end
    endtask

    task automatic test_host_cmd;
        int v0, e0;
        logic ok;
        v0 = n_valid; e0 = n_error;
        host_send(8'hFF, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cmd_clocks: got ok=%b expected 1", ok); end
        repeat (HP / 2) @(negedge clk);
        checks++; if (dataps2 !== 1'b0) begin errors++; $display("FAIL cmd_ack: got data=%b expected 0", dataps2); end
        for (int k = 0; k < 4 * HP && n_valid == v0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (n_valid != v0 + 1 || n_error != e0) begin errors++; $display("FAIL cmd_pulses: got valid=%0d error=%0d expected 1 0", n_valid - v0, n_error - e0); end
        checks++; if (bus.rx_data !== 8'hFF) begin errors++; $display("FAIL cmd_rx_data: got %h expected FF", bus.rx_data); end
        checks++; if (bus.busy !== 1'b0 || dataps2 !== 1'b1) begin errors++; $display("FAIL cmd_end_state: got busy=%b data=%b expected 0 1", bus.busy, dataps2); end
    endtask

    task automatic test_bad_parity;
        int v0, e0;
        logic ok;
        v0 = n_valid; e0 = n_error;
        // 0xF4 has five ones, so a parity bit of 1 makes the frame even.
        host_send(8'hF4, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL badp_clocks: got ok=%b expected 1", ok); end
        repeat (HP / 2) @(negedge clk);
        checks++; if (dataps2 !== 1'b0) begin errors++; $display("FAIL badp_ack: got data=%b expected 0", dataps2); end
        for (int k = 0; k < 4 * HP && n_error == e0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (n_error != e0 + 1 || n_valid != v0) begin errors++; $display("FAIL badp_pulses: got error=%0d valid=%0d expected 1 0", n_error - e0, n_valid - v0); end
        checks++; if (bus.rx_data !== 8'hFF) begin errors++; $display("FAIL badp_rx_data: got %h expected FF", bus.rx_data); end
    endtask

    task automatic test_reset_mid_tx;
        int base, base2, d0;
        base = rec_n; d0 = n_done; rec_en = 1'b1;
        do_load(8'h3C);
        for (int k = 0; k < 2000 && rec_n - base < 8; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (clkps2 !== 1'b0 || dataps2 !== 1'b0) begin errors++; $display("FAIL rst_mid_driven: got clk=%b data=%b expected 0 0", clkps2, dataps2); end
        rst_n = 1'b0;
        #1;
        checks++; if (clkps2 !== 1'b1 || dataps2 !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release: got clk=%b data=%b busy=%b expected 1 1 0", clkps2, dataps2, bus.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base2 = rec_n;
        repeat (2 * GAP + 6 * HP) @(negedge clk);
        rec_en = 1'b0;
        checks++; if (rec_n != base2 || n_done != d0) begin errors++; $display("FAIL rst_mid_silent: got falls=%0d done=%0d expected 0 0", rec_n - base2, n_done - d0); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data: got %h expected 00", bus.rx_data); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_transmit;
        test_back_to_back;
        test_inhibit;
        test_host_cmd;
        test_bad_parity;
        test_reset_mid_tx;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
